// File: rtl/video_timing.sv
// Raster timing generator: signed pixel/line counters with blanking at negative
// coordinates, plus registered sync, blank and frame-start strobes aligned to the counters.
module video_timing #(
  parameter int HACTIVE  = 800,
  parameter int HFP      = 40,
  parameter int HSYNC    = 128,
  parameter int HBP      = 88,
  parameter int VACTIVE  = 600,
  parameter int VFP      = 1,
  parameter int VSYNC    = 4,
  parameter int VBP      = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic signed [10:0] spotX,
  output logic signed [10:0] spotY,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start
);

  localparam int HB = HFP + HSYNC + HBP;
  localparam int VB = VFP + VSYNC + VBP;

  localparam logic signed [10:0] X_FIRST  = 11'(-HB);
  localparam logic signed [10:0] X_LAST   = 11'(HACTIVE - 1);
  localparam logic signed [10:0] HS_FIRST = 11'(-HSYNC - HBP);
  localparam logic signed [10:0] HS_LAST  = 11'(-HBP - 1);
  localparam logic signed [10:0] Y_FIRST  = 11'(-VB);
  localparam logic signed [10:0] Y_LAST   = 11'(VACTIVE - 1);
  localparam logic signed [10:0] VS_FIRST = 11'(-VSYNC - VBP);
  localparam logic signed [10:0] VS_LAST  = 11'(-VBP - 1);
  localparam logic signed [10:0] ZERO     = 11'sd0;

  logic signed [10:0] x_next;
  logic signed [10:0] y_next;
  logic               x_wrap;
  logic               frame_wrap;
  logic               hs_next;
  logic               vs_next;
  logic               blank_next;

  // Decode regions from the next coordinates so the strobes land with the counters.
  always_comb begin
    x_wrap     = (spotX == X_LAST);
    frame_wrap = x_wrap && (spotY == Y_LAST);
    x_next     = x_wrap ? X_FIRST : spotX + 11'sd1;
    y_next     = spotY;
    if (x_wrap) begin
      y_next = (spotY == Y_LAST) ? Y_FIRST : spotY + 11'sd1;
    end
    hs_next    = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
    vs_next    = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
    blank_next = (x_next < ZERO) || (y_next < ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spotX       <= X_FIRST;
      spotY       <= Y_FIRST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else if (en) begin
      spotX       <= x_next;
      spotY       <= y_next;
      hsync       <= hs_next ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_next ? SYNC_POL : ~SYNC_POL;
      blank       <= blank_next;
      frame_start <= frame_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Drives three video_timing builds (defaults, reduced geometry, reduced with inverted
// sync polarity) and compares them every cycle against a raster-index reference model.
module tb_video_timing;

  logic clk;
  logic rst;
  logic en;

  logic signed [10:0] ox [3];
  logic signed [10:0] oy [3];
  logic               ohs [3];
  logic               ovs [3];
  logic               obl [3];
  logic               ofs [3];

  int p_ref [3];
  int fs_ref [3];
  int errors;
  int checks;

  video_timing dut_def (
    .clk(clk), .rst(rst), .en(en),
    .spotX(ox[0]), .spotY(oy[0]), .hsync(ohs[0]), .vsync(ovs[0]),
    .blank(obl[0]), .frame_start(ofs[0])
  );

  video_timing #(
    .HACTIVE(40), .HFP(4), .HSYNC(8), .HBP(6),
    .VACTIVE(20), .VFP(1), .VSYNC(3), .VBP(4), .SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .rst(rst), .en(en),
    .spotX(ox[1]), .spotY(oy[1]), .hsync(ohs[1]), .vsync(ovs[1]),
    .blank(obl[1]), .frame_start(ofs[1])
  );

  video_timing #(
    .HACTIVE(40), .HFP(4), .HSYNC(8), .HBP(6),
    .VACTIVE(20), .VFP(1), .VSYNC(3), .VBP(4), .SYNC_POL(1'b0)
  ) dut_inv (
    .clk(clk), .rst(rst), .en(en),
    .spotX(ox[2]), .spotY(oy[2]), .hsync(ohs[2]), .vsync(ovs[2]),
    .blank(obl[2]), .frame_start(ofs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void getParams(input int i, output int ha, output int hfp, output int hs,
                                    output int hbp, output int va, output int vfp, output int vs,
                                    output int vbp, output int pol);
    if (i == 0) begin
      ha = 800; hfp = 40; hs = 128; hbp = 88; va = 600; vfp = 1; vs = 4; vbp = 23; pol = 1;
    end else begin
      ha = 40; hfp = 4; hs = 8; hbp = 6; va = 20; vfp = 1; vs = 3; vbp = 4;
      pol = (i == 1) ? 1 : 0;
    end
  endfunction

  function automatic int frameLen(input int i);
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol;
    getParams(i, ha, hfp, hs, hbp, va, vfp, vs, vbp, pol);
    return (ha + hfp + hs + hbp) * (va + vfp + vs + vbp);
  endfunction

  task automatic checkVal(input string tag, input int inst, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s inst%0d got=%0d want=%0d at %0t", tag, inst, got, want, $time);
    end
  endtask

  // The model tracks a linear raster index: column = p % line length, row = p / line length.
  task automatic updateModel();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        p_ref[i] = 0;
        fs_ref[i] = 0;
      end else if (en) begin
        p_ref[i] = (p_ref[i] + 1) % frameLen(i);
        fs_ref[i] = (p_ref[i] == 0) ? 1 : 0;
      end else begin
        fs_ref[i] = 0;
      end
    end
  endtask

  task automatic checkOutput();
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol;
    int ht, hb, vb, col, row;
    for (int i = 0; i < 3; i++) begin
      getParams(i, ha, hfp, hs, hbp, va, vfp, vs, vbp, pol);
      hb  = hfp + hs + hbp;
      vb  = vfp + vs + vbp;
      ht  = ha + hb;
      col = p_ref[i] % ht;
      row = p_ref[i] / ht;
      checkVal("spotX", i, int'(ox[i]), col - hb);
      checkVal("spotY", i, int'(oy[i]), row - vb);
      checkVal("hsync", i, int'(ohs[i]), (col >= hfp && col < hfp + hs) ? pol : 1 - pol);
      checkVal("vsync", i, int'(ovs[i]), (row >= vfp && row < vfp + vs) ? pol : 1 - pol);
      checkVal("blank", i, int'(obl[i]), (col < hb || row < vb) ? 1 : 0);
      checkVal("frame_start", i, int'(ofs[i]), fs_ref[i]);
    end
  endtask

  task automatic applyStimulus(input logic en_v);
    en = en_v;
    @(posedge clk);
    updateModel();
    #1;
    checkOutput();
  endtask

  initial begin
    int hs_cnt, bl_cnt, fs_cnt, vs1_cnt, vs2_cnt, fs1_cnt;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_ref[i] = 0;
      fs_ref[i] = 0;
    end

    $display("[TB] reset state");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1);
    #2 rst = 1'b0;

    $display("[TB] first default line");
    hs_cnt = 0; bl_cnt = 0; fs_cnt = 0;
    for (int k = 0; k < 1056; k++) begin
      applyStimulus(1'b1);
      if (ohs[0] === 1'b1) hs_cnt++;
      if (obl[0] === 1'b0) bl_cnt++;
      if (ofs[0] === 1'b1) fs_cnt++;
    end
    checkVal("line_hsync_cycles", 0, hs_cnt, 128);
    checkVal("line_unblanked", 0, bl_cnt, 0);
    checkVal("line_no_frame_start", 0, fs_cnt, 0);
    checkVal("line_wrap_x", 0, int'(ox[0]), -256);
    checkVal("line_wrap_y", 0, int'(oy[0]), -27);

    $display("[TB] random enable");
    for (int k = 0; k < 3500; k++) applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    $display("[TB] pause at last pixel");
    for (int k = 0; k < 4000 && p_ref[1] != frameLen(1) - 1; k++) applyStimulus(1'b1);
    checkVal("reach_last_x", 1, int'(ox[1]), 39);
    checkVal("reach_last_y", 1, int'(oy[1]), 19);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0);
    checkVal("frozen_x", 1, int'(ox[1]), 39);
    applyStimulus(1'b1);
    checkVal("reenable_fs", 1, int'(ofs[1]), 1);
    checkVal("reenable_x", 1, int'(ox[1]), -18);
    checkVal("reenable_y", 1, int'(oy[1]), -8);

    $display("[TB] asynchronous reset mid-frame");
    for (int k = 0; k < 700; k++) applyStimulus(1'b1);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      p_ref[i] = 0;
      fs_ref[i] = 0;
    end
    checkOutput();
    applyStimulus(1'b1);
    #2 rst = 1'b0;

    $display("[TB] full reduced frame");
    vs1_cnt = 0; vs2_cnt = 0; fs1_cnt = 0;
    for (int k = 0; k < frameLen(1); k++) begin
      applyStimulus(1'b1);
      if (k == 0) checkVal("no_fs_after_reset", 1, int'(ofs[1]), 0);
      if (ovs[1] === 1'b1) vs1_cnt++;
      if (ovs[2] === 1'b0) vs2_cnt++;
      if (ofs[1] === 1'b1) fs1_cnt++;
    end
    checkVal("frame_vsync_cycles", 1, vs1_cnt, 3 * 58);
    checkVal("frame_vsync_cycles_inv", 2, vs2_cnt, 3 * 58);
    checkVal("frame_fs_count", 1, fs1_cnt, 1);
    checkVal("frame_end_y", 1, int'(oy[1]), -8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- HACTIVE, 800, active pixels per line.
- HFP, 40, horizontal front porch in clocks.
- HSYNC, 128, horizontal sync width in clocks.
- HBP, 88, horizontal back porch in clocks.
- VACTIVE, 600, active lines per frame.
- VFP, 1, vertical front porch in lines.
- VSYNC, 4, vertical sync width in lines.
- VBP, 23, vertical back porch in lines.
- SYNC_POL, 1, sync active level (1 = active-high).
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, pixel clock (40 MHz for the defaults).
- rst, in, 1, reset; asynchronous, active-high.
- en, in, 1, advance enable; counters hold while low.
- spotX, out, signed 11, current pixel column.
- spotY, out, signed 11, current line.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- blank, out, 1, high outside the active area.
- frame_start, out, 1, one-cycle pulse on the first pixel of a frame.
REQ-003 The block SHALL have one clock domain (clk); reset SHALL be asynchronous and active-high (rst).

Function
REQ-004 HB = HFP+HSYNC+HBP and VB = VFP+VSYNC+VBP; the defaults SHALL give HB = 256, VB = 28, 1056 clocks/line, 628 lines/frame.
REQ-005 spotX SHALL count -HB..HACTIVE-1; blanking is negative, active area is 0..HACTIVE-1.
REQ-006 With en=1, spotX SHALL increment by 1 each clk; at HACTIVE-1 it SHALL wrap to -HB on the next cycle.
REQ-007 spotY SHALL range -VB..VACTIVE-1.
REQ-008 spotY SHALL increment only on the cycle where spotX wraps; at VACTIVE-1 it SHALL wrap to -VB together with spotX.
REQ-009 With en=0, spotX, spotY, hsync, vsync and blank SHALL hold their values, and frame_start SHALL be 0.
REQ-010 Horizontal regions, relative to spotX:
- front porch: -HB .. -HB+HFP-1 (default -256..-217).
- sync: -HSYNC-HBP .. -HBP-1 (default -216..-89).
- back porch: -HBP .. -1 (default -88..-1).
REQ-011 Vertical regions, relative to spotY, default values:
- front porch: -28.
- sync: -27..-24.
- back porch: -23..-1.
REQ-012 hsync SHALL equal SYNC_POL while spotX is in the horizontal sync range, else ~SYNC_POL.
REQ-013 vsync SHALL equal SYNC_POL for every clock of a line whose spotY is in the vertical sync range, else ~SYNC_POL.
REQ-014 blank SHALL be 1 iff spotX<0 or spotY<0.
REQ-015 All outputs SHALL be registered and mutually aligned: hsync, vsync, blank and frame_start describe the same (spotX, spotY) presented in the same cycle, with zero relative skew.
REQ-016 frame_start SHALL be 1 for exactly one enabled cycle, the one where (spotX, spotY) = (-HB, -VB) is entered by wrap.
REQ-017 frame_start SHALL NOT pulse on the first cycle after reset release.
REQ-018 Counter arithmetic SHALL be signed 11-bit. Parameter sets requiring values outside -1024..1023 are unsupported.

Reset
REQ-019 While rst=1, outputs SHALL be:
- spotX = -HB and spotY = -VB (default -256 and -28).
- hsync = vsync = ~SYNC_POL.
- blank = 1.
- frame_start = 0.
REQ-020 Reset asserted mid-frame SHALL force REQ-019 values immediately, without waiting for a clock edge.
REQ-021 After reset deasserts, counting SHALL resume from (-HB, -VB) on the first enabled clk edge.

Verification
REQ-022 Reset then en=1 for 1056 clocks -> spotX runs -256..799 and returns to -256; spotY goes -28 -> -27 exactly at the wrap; no frame_start.
REQ-023 Run one line -> hsync high exactly for 128 clocks (spotX -216..-89); blank low exactly for spotX 0..799 once spotY >= 0.
REQ-024 Run 628x1056 clocks -> vsync high for exactly 4x1056 clocks (spotY -27..-24); one frame_start at the frame wrap; spotY then back to -28.
REQ-025 Toggle en low for 10 clocks at spotX=799, spotY=599 -> all outputs frozen; on re-enable the next cycle is (-256, -28) with frame_start=1.
REQ-026 Assert rst asynchronously (between edges) at spotX=400, spotY=300 -> outputs at REQ-019 values before the next clk edge.
REQ-027 SYNC_POL=0 build, rerun REQ-023 -> hsync and vsync inverted, all timing identical.
